rvz_decode_stage: RTL

Parametrised decode stage for the riscv_zero core. It sits between fetch and execute and holds a 32x XLEN register file with one write port and two read ports. It decodes RV32I/RV64I base opcodes into sign-extended immediates and execute/memory/writeback controls. Adds a valid/ready pipeline handshake, flush, write-to-read bypass, held-operand refresh and illegal-opcode flagging.

---
 rtl/rvz_decode_stage.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/rvz_decode_stage.sv
// rtl/rvz_decode_stage.sv - riscv_zero decode stage with register file, handshake and bypass
module rvz_decode_stage #(
  parameter int XLEN   = 64,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst_data,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  input  logic            reg_wenable,
  input  logic [4:0]      reg_waddr,
  input  logic [XLEN-1:0] reg_wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] immediate,
  output logic [4:0]      reg_dest,
  output logic [XLEN-1:0] reg1_out,
  output logic [XLEN-1:0] reg2_out,
  output logic [XLEN-1:0] pc_out,
  output logic            writeback_enable,
  output logic [1:0]      writeback_source,
  output logic [1:0]      memory_access,
  output logic            jump,
  output logic            branch,
  output logic            ALU_A_mux,
  output logic            ALU_B_mux,
  output logic            illegal
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_OP32  = 7'b0111011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic [XLEN-1:0] regs [32];
  logic [4:0]      rs1, rs2, rs1_q, rs2_q;
  logic [XLEN-1:0] rd1, rd2, imm_d;
  logic [31:0]     imm32;
  logic            accept, stall;
  logic            wb_en_d, jump_d, branch_d, a_mux_d, b_mux_d, illegal_d;
  logic [1:0]      wb_src_d, mem_d;

  assign rs1      = inst_data[19:15];
  assign rs2      = inst_data[24:20];
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign stall    = out_valid && !out_ready;

  // Read ports: x0 is hardwired zero, optionally forward the same-cycle write
  always_comb begin
    rd1 = regs[rs1];
    rd2 = regs[rs2];
    if (BYPASS && reg_wenable && reg_waddr == rs1) rd1 = reg_wdata;
    if (BYPASS && reg_wenable && reg_waddr == rs2) rd2 = reg_wdata;
    if (rs1 == 5'd0) rd1 = '0;
    if (rs2 == 5'd0) rd2 = '0;
  end

  // Immediate decode from the incoming word, sign-extended from bit 31
  always_comb begin
    imm32 = '0;
    case (inst_data[6:0])
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR:
        imm32 = {{20{inst_data[31]}}, inst_data[31:20]};
      OP_STORE:
        imm32 = {{20{inst_data[31]}}, inst_data[31:25], inst_data[11:7]};
      OP_BR:
        imm32 = {{20{inst_data[31]}}, inst_data[7], inst_data[30:25], inst_data[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm32 = {inst_data[31:12], 12'b0};
      OP_JAL:
        imm32 = {{12{inst_data[31]}}, inst_data[19:12], inst_data[20], inst_data[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm_d = XLEN'($signed(imm32));
  end

  // Control decode; the 32-bit word ops only exist on a 64-bit core
  always_comb begin
    wb_en_d   = 1'b0;
    wb_src_d  = 2'b00;
    mem_d     = 2'b00;
    jump_d    = 1'b0;
    branch_d  = 1'b0;
    a_mux_d   = 1'b0;
    b_mux_d   = 1'b0;
    illegal_d = 1'b0;
    case (inst_data[6:0])
      OP_LOAD:  begin mem_d = 2'b01; wb_en_d = 1'b1; wb_src_d = 2'b01; b_mux_d = 1'b1; end
      OP_IMM:   begin wb_en_d = 1'b1; b_mux_d = 1'b1; end
      OP_IMM32: begin
        if (XLEN == 64) begin wb_en_d = 1'b1; b_mux_d = 1'b1; end
        else illegal_d = 1'b1;
      end
      OP_AUIPC: begin wb_en_d = 1'b1; a_mux_d = 1'b1; b_mux_d = 1'b1; end
      OP_STORE: begin mem_d = 2'b10; b_mux_d = 1'b1; end
      OP_OP:    wb_en_d = 1'b1;
      OP_OP32: begin
        if (XLEN == 64) wb_en_d = 1'b1;
        else illegal_d = 1'b1;
      end
      OP_LUI:   begin wb_en_d = 1'b1; wb_src_d = 2'b10; end
      OP_BR:    branch_d = 1'b1;
      OP_JALR:  begin jump_d = 1'b1; wb_en_d = 1'b1; wb_src_d = 2'b11; b_mux_d = 1'b1; end
      OP_JAL:   begin jump_d = 1'b1; wb_en_d = 1'b1; wb_src_d = 2'b11; a_mux_d = 1'b1; b_mux_d = 1'b1; end
      default:  illegal_d = 1'b1;
    endcase
  end

  // Register file: single write port, x0 writes discarded
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (reg_wenable && reg_waddr != 5'd0) begin
      regs[reg_waddr] <= reg_wdata;
    end
  end

  // Pipeline register: load on accept, refresh held operands while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid        <= 1'b0;
      opcode           <= '0;
      funct3           <= '0;
      funct7           <= '0;
      immediate        <= '0;
      reg_dest         <= '0;
      reg1_out         <= '0;
      reg2_out         <= '0;
      pc_out           <= '0;
      writeback_enable <= 1'b0;
      writeback_source <= '0;
      memory_access    <= '0;
      jump             <= 1'b0;
      branch           <= 1'b0;
      ALU_A_mux        <= 1'b0;
      ALU_B_mux        <= 1'b0;
      illegal          <= 1'b0;
      rs1_q            <= '0;
      rs2_q            <= '0;
    end else begin
      if (accept) begin
        opcode           <= inst_data[6:0];
        funct3           <= inst_data[14:12];
        funct7           <= inst_data[31:25];
        immediate        <= imm_d;
        reg_dest         <= inst_data[11:7];
        reg1_out         <= rd1;
        reg2_out         <= rd2;
        pc_out           <= pc_in;
        writeback_enable <= wb_en_d;
        writeback_source <= wb_src_d;
        memory_access    <= mem_d;
        jump             <= jump_d;
        branch           <= branch_d;
        ALU_A_mux        <= a_mux_d;
        ALU_B_mux        <= b_mux_d;
        illegal          <= illegal_d;
        rs1_q            <= rs1;
        rs2_q            <= rs2;
      end else if (stall && reg_wenable && reg_waddr != 5'd0) begin
        if (reg_waddr == rs1_q) reg1_out <= reg_wdata;
        if (reg_waddr == rs2_q) reg2_out <= reg_wdata;
      end
      if (accept) out_valid <= 1'b1;
      else if (flush || out_ready) out_valid <= 1'b0;
    end
  end

endmodule
